bcd_time_counter: RTL and testbench

Time-of-day counter for the digital clock, sitting directly upstream of the per-digit 7-segment decoders. It divides the system clock to a 1 Hz tick and keeps hours, minutes and seconds as six BCD digits in 24-hour format, each driving one 4-bit decoder input. A set mode lets the user adjust hours and minutes with single-cycle increment pulses.

---
 rtl/bcd_time_counter.sv | 86 ++++++++
 tb/tb_bcd_time_counter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// 24-hour time-of-day counter: divides clk to a 1 Hz tick and keeps HH:MM:SS as six registered BCD digits.
// A set mode clears the seconds and accepts hour/minute increment pulses.
module bcd_time_counter #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       set_mode,
   input  logic       inc_hour,
   input  logic       inc_min,
   output logic [3:0] hr_tens,
   output logic [3:0] hr_ones,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       sec_pulse,
   output logic       day_wrap
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   logic [PW-1:0] presc;
   logic          tick;
   logic          sec_wrap;
   logic          min_wrap;
   logic          hr_wrap;

   function automatic logic [3:0] digit_next(input logic [3:0] d, input logic [3:0] lim);
      return (d == lim) ? 4'd0 : d + 4'd1;
   endfunction

   // Minutes count 00..59 as a {tens, ones} pair.
   function automatic logic [7:0] min_next(input logic [3:0] t, input logic [3:0] o);
      if (o == 4'd9) return {digit_next(t, 4'd5), 4'd0};
      else           return {t, o + 4'd1};
   endfunction

   // Hours count 00..23; 23 wraps to 00 regardless of the ones digit rule.
   function automatic logic [7:0] hour_next(input logic [3:0] t, input logic [3:0] o);
      if (t == 4'd2 && o == 4'd3) return 8'h00;
      else if (o == 4'd9)         return {t + 4'd1, 4'd0};
      else                        return {t, o + 4'd1};
   endfunction

   assign tick     = (presc == PW'(CLK_HZ - 1)) && run && !set_mode;
   assign sec_wrap = (sec_tens == 4'd5) && (sec_ones == 4'd9);
   assign min_wrap = (min_tens == 4'd5) && (min_ones == 4'd9);
   assign hr_wrap  = (hr_tens == 4'd2) && (hr_ones == 4'd3);

   always_ff @(posedge clk) begin
      if (rst) begin
         presc     <= '0;
         hr_tens   <= 4'd0;
         hr_ones   <= 4'd0;
         min_tens  <= 4'd0;
         min_ones  <= 4'd0;
         sec_tens  <= 4'd0;
         sec_ones  <= 4'd0;
         sec_pulse <= 1'b0;
         day_wrap  <= 1'b0;
      end else begin
         sec_pulse <= 1'b0;
         day_wrap  <= 1'b0;
         if (set_mode) begin
            presc    <= '0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            if (inc_min)  {min_tens, min_ones} <= min_next(min_tens, min_ones);
            if (inc_hour) {hr_tens, hr_ones}   <= hour_next(hr_tens, hr_ones);
         end else if (tick) begin
            presc     <= '0;
            sec_pulse <= 1'b1;
            day_wrap  <= sec_wrap && min_wrap && hr_wrap;
            sec_ones  <= digit_next(sec_ones, 4'd9);
            if (sec_ones == 4'd9) sec_tens <= digit_next(sec_tens, 4'd5);
            if (sec_wrap) {min_tens, min_ones} <= min_next(min_tens, min_ones);
            if (sec_wrap && min_wrap) {hr_tens, hr_ones} <= hour_next(hr_tens, hr_ones);
         end else if (run) begin
            presc <= presc + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter with CLK_HZ=4; expected times are hand-computed BCD constants.
module tb_bcd_time_counter;

   localparam int HZ = 4;

   logic       clk = 1'b0;
   logic       rst, run, set_mode, inc_hour, inc_min;
   logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
   logic       sec_pulse, day_wrap;
   logic [23:0] tod;
   logic       range_bad = 1'b0;
   logic       any_pulse;
   int         n_total = 0;
   int         n_pass = 0;

   bcd_time_counter #(.CLK_HZ(HZ)) dut (
      .clk(clk), .rst(rst), .run(run), .set_mode(set_mode),
      .inc_hour(inc_hour), .inc_min(inc_min),
      .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
      .sec_tens(sec_tens), .sec_ones(sec_ones), .sec_pulse(sec_pulse), .day_wrap(day_wrap)
   );

   always #5 clk = ~clk;

   assign tod = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

   always @(negedge clk) begin
      if (hr_tens > 4'd2 || hr_ones > 4'd9 || (hr_tens == 4'd2 && hr_ones > 4'd3) ||
          min_tens > 4'd5 || min_ones > 4'd9 || sec_tens > 4'd5 || sec_ones > 4'd9)
         range_bad = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_inc(input logic h, input logic m, input int n);
      for (int i = 0; i < n; i++) begin
         inc_hour = h;
         inc_min  = m;
         step(1);
      end
      inc_hour = 1'b0;
      inc_min  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; set_mode = 1'b0; inc_hour = 1'b0; inc_min = 1'b0;

      // Reset and first tick
      step(2);
      check("rst_tod", tod, 24'h000000);
      check("rst_pulse", sec_pulse, 1'b0);
      check("rst_wrap", day_wrap, 1'b0);
      rst = 1'b0; run = 1'b1;
      step(3);
      check("pre_tick_pulse", sec_pulse, 1'b0);
      check("pre_tick_tod", tod, 24'h000000);
      step(1);
      check("tick1_pulse", sec_pulse, 1'b1);
      check("tick1_tod", tod, 24'h000001);
      step(1);
      check("tick1_end", sec_pulse, 1'b0);
      step(3);
      check("tick2_pulse", sec_pulse, 1'b1);
      check("tick2_tod", tod, 24'h000002);

      // Full cascade through midnight
      rst = 1'b1; step(1); rst = 1'b0;
      set_mode = 1'b1;
      pulse_inc(1'b1, 1'b0, 23);
      pulse_inc(1'b0, 1'b1, 59);
      check("load_2359", tod, 24'h235900);
      set_mode = 1'b0;
      step(HZ * 58);
      check("t235958", tod, 24'h235958);
      check("t235958_wrap", day_wrap, 1'b0);
      step(HZ);
      check("t235959", tod, 24'h235959);
      check("t235959_wrap", day_wrap, 1'b0);
      step(HZ);
      check("midnight_tod", tod, 24'h000000);
      check("midnight_pulse", sec_pulse, 1'b1);
      check("midnight_wrap", day_wrap, 1'b1);
      step(1);
      check("midnight_wrap_end", day_wrap, 1'b0);

      // Minute and hour boundaries
      step(HZ * 599 - 1);
      check("t000959", tod, 24'h000959);
      step(HZ);
      check("t001000", tod, 24'h001000);
      set_mode = 1'b1;
      pulse_inc(1'b1, 1'b0, 9);
      pulse_inc(1'b0, 1'b1, 49);
      check("load_0959", tod, 24'h095900);
      set_mode = 1'b0;
      step(HZ * 59);
      check("t095959", tod, 24'h095959);
      step(HZ);
      check("t100000", tod, 24'h100000);

      // Set mode behaviour
      set_mode = 1'b1;
      pulse_inc(1'b1, 1'b0, 2);
      pulse_inc(1'b0, 1'b1, 34);
      set_mode = 1'b0;
      step(HZ * 56);
      check("t123456", tod, 24'h123456);
      set_mode = 1'b1;
      step(1);
      check("set_sec_clear", tod, 24'h123400);
      pulse_inc(1'b0, 1'b1, 26);
      check("min_wrap_no_carry", tod, 24'h120000);
      pulse_inc(1'b1, 1'b0, 11);
      pulse_inc(1'b0, 1'b1, 59);
      check("load_2359_b", tod, 24'h235900);
      pulse_inc(1'b1, 1'b1, 1);
      check("both_inc_wrap", tod, 24'h000000);
      check("inc_no_pulse", sec_pulse, 1'b0);
      check("inc_no_wrap", day_wrap, 1'b0);
      set_mode = 1'b0; run = 1'b0;
      pulse_inc(1'b1, 1'b1, 3);
      check("inc_ignored", tod, 24'h000000);

      // Pause mid-second at prescaler 2
      run = 1'b1;
      step(2);
      run = 1'b0;
      any_pulse = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         any_pulse = any_pulse | sec_pulse;
      end
      check("pause_no_pulse", any_pulse, 1'b0);
      check("pause_hold", tod, 24'h000000);
      run = 1'b1;
      step(1);
      check("resume_c1", sec_pulse, 1'b0);
      step(1);
      check("resume_c2_pulse", sec_pulse, 1'b1);
      check("resume_c2_tod", tod, 24'h000001);

      // Reset in the middle of operation
      set_mode = 1'b1;
      pulse_inc(1'b1, 1'b0, 15);
      pulse_inc(1'b0, 1'b1, 47);
      set_mode = 1'b0;
      step(HZ * 33);
      check("t154733", tod, 24'h154733);
      step(2);
      set_mode = 1'b1; rst = 1'b1;
      step(1);
      set_mode = 1'b0;
      step(1);
      check("midrst_tod", tod, 24'h000000);
      check("midrst_pulse", sec_pulse, 1'b0);
      check("midrst_wrap", day_wrap, 1'b0);
      rst = 1'b0;
      step(HZ - 1);
      check("midrst_presc0", sec_pulse, 1'b0);
      step(1);
      check("midrst_tick", sec_pulse, 1'b1);
      check("midrst_tick_tod", tod, 24'h000001);

      check("digit_range", range_bad, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
